// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial output bundle for piso_shift_tx.
// Ports: Load_valid/Load_ready/D (parallel word in), Sout/Sout_valid (serial out),
//        Busy (frame in progress), Done (one-cycle end-of-frame pulse).
interface piso_shift_tx_if #(
  parameter int WIDTH = 4
);
  logic             Load_valid;
  logic             Load_ready;
  logic [WIDTH-1:0] D;
  logic             Sout;
  logic             Sout_valid;
  logic             Busy;
  logic             Done;

  // Transmitter side.
  modport slave (
    input  Load_valid, D,
    output Load_ready, Sout, Sout_valid, Busy, Done
  );

  // Word source / serial consumer side.
  modport master (
    output Load_valid, D,
    input  Load_ready, Sout, Sout_valid, Busy, Done
  );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: captures a WIDTH-bit word on a valid/ready
// load and shifts it out one bit per CLK, then pulses Done for one cycle.
// Latency: first bit the cycle after the load edge; frame is WIDTH cycles
// (WIDTH+1 with PISO_PARITY_EN defined, which appends an even-parity bit).
// Backpressure: Load_ready is high only in IDLE; Load_valid is ignored mid-frame.
// Ports: CLK, CLR (async active-low), bus (piso_shift_tx_if.slave).
module piso_shift_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             CLR,
  piso_shift_tx_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             out_bit;
  logic [WIDTH-1:0] sreg_shifted;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  // Output end of the register and the shift toward it (zero fill).
  assign out_bit      = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, sreg_q[WIDTH-1:1]};

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.Load_valid) begin
          sreg_d  = bus.D;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef PISO_PARITY_EN
          par_d   = ^bus.D;
`endif
        end
      end
      SHIFT: begin
        sreg_d = sreg_shifted;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Clear rather than increment so the counter never wraps.
          cnt_d = '0;
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Handshake and serial outputs decode straight from state so that an
  // asynchronous reset drops them immediately.
  always_comb begin
    bus.Load_ready = (state_q == IDLE);
    bus.Busy       = (state_q != IDLE);
    bus.Sout_valid = (state_q != IDLE);
    bus.Sout       = 1'b0;
    if (state_q == SHIFT) bus.Sout = out_bit;
`ifdef PISO_PARITY_EN
    if (state_q == PARITY) bus.Sout = par_q;
`endif
  end

  assign bus.Done = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: an LSB-first and an MSB-first
// instance share the same stimulus; each is checked against a bit-order model.
module tb_piso_shift_tx;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = W + PAR;

  logic         clk;
  logic         clr;
  logic         lv;
  logic [W-1:0] d;
  int           checks;
  int           errors;

  piso_shift_tx_if #(.WIDTH(W)) if0 ();
  piso_shift_tx_if #(.WIDTH(W)) if1 ();

  assign if0.Load_valid = lv;
  assign if0.D          = d;
  assign if1.Load_valid = lv;
  assign if1.D          = d;

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .CLK (clk),
    .CLR (clr),
    .bus (if0.slave)
  );

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .CLK (clk),
    .CLR (clr),
    .bus (if1.slave)
  );

  // {Sout_valid, Busy, Load_ready, Done}
  logic [3:0] st0, st1;
  assign st0 = {if0.Sout_valid, if0.Busy, if0.Load_ready, if0.Done};
  assign st1 = {if1.Sout_valid, if1.Busy, if1.Load_ready, if1.Done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the i-th transmitted bit of word w for a given bit order.
  function automatic logic exp_bit(input logic [W-1:0] w, input int i, input bit msb);
    if (i < W) return msb ? w[W-1-i] : w[i];
    return ^w;
  endfunction

  // Called at a negedge with both instances in IDLE (possibly the Done cycle).
  // Transfers w, checks every frame bit, returns at the negedge of the Done cycle.
  task automatic run_frame(input logic [W-1:0] w, input bit keep_valid,
                           input logic [W-1:0] next_d);
    checks++;
    if (if0.Load_ready !== 1'b1 || if1.Load_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_load: got %b/%b want 1/1", if0.Load_ready, if1.Load_ready);
    end
    lv = 1'b1;
    d  = w;
    @(posedge clk);
    @(negedge clk);
    lv = keep_valid;
    d  = next_d;
    for (int i = 0; i < FL; i++) begin
      checks++;
      if (if0.Sout !== exp_bit(w, i, 1'b0)) begin
        errors++;
        $display("FAIL lsb_sout word=%h bit%0d: got %b want %b", w, i, if0.Sout, exp_bit(w, i, 1'b0));
      end
      checks++;
      if (if1.Sout !== exp_bit(w, i, 1'b1)) begin
        errors++;
        $display("FAIL msb_sout word=%h bit%0d: got %b want %b", w, i, if1.Sout, exp_bit(w, i, 1'b1));
      end
      checks++;
      if (st0 !== 4'b1100 || st1 !== 4'b1100) begin
        errors++;
        $display("FAIL frame_status word=%h bit%0d: got %b/%b want 1100/1100", w, i, st0, st1);
      end
      @(negedge clk);
    end
    checks++;
    if (st0 !== 4'b0011 || st1 !== 4'b0011 || if0.Sout !== 1'b0 || if1.Sout !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle word=%h: got %b/%b sout %b%b want 0011/0011 sout 00",
               w, st0, st1, if0.Sout, if1.Sout);
    end
  endtask

  task automatic test_reset;
    clr = 1'b0;
    lv  = 1'b0;
    d   = '0;
    #3;
    checks++;
    if (st0 !== 4'b0010 || st1 !== 4'b0010 || if0.Sout !== 1'b0 || if1.Sout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got %b/%b sout %b%b want 0010/0010 sout 00", st0, st1, if0.Sout, if1.Sout);
    end
    lv = 1'b1;
    d  = W'($urandom);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (st0 !== 4'b0010 || st1 !== 4'b0010) begin
        errors++;
        $display("FAIL reset_ignores_load: got %b/%b want 0010/0010", st0, st1);
      end
    end
    lv  = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    checks++;
    if (st0 !== 4'b0010 || st1 !== 4'b0010) begin
      errors++;
      $display("FAIL idle_after_release: got %b/%b want 0010/0010", st0, st1);
    end
  endtask

  task automatic test_fixed_words;
    run_frame(4'b1011, 1'b0, 4'b0000);
    @(negedge clk);
    checks++;
    if (if0.Done !== 1'b0 || if1.Done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle: got %b/%b want 0/0", if0.Done, if1.Done);
    end
    run_frame(4'b0011, 1'b0, 4'b1100);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    // Load_valid stays high; D switches to 5 mid-frame and is taken on the Done cycle.
    run_frame(4'hA, 1'b1, 4'h5);
    run_frame(4'h5, 1'b0, 4'hF);
    @(negedge clk);
    checks++;
    if (st0 !== 4'b0010 || st1 !== 4'b0010) begin
      errors++;
      $display("FAIL idle_after_b2b: got %b/%b want 0010/0010", st0, st1);
    end
  endtask

  task automatic test_reset_midframe;
    lv = 1'b1;
    d  = 4'hF;
    @(posedge clk);
    @(negedge clk);
    lv = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    clr = 1'b0;
    #1;
    checks++;
    if (st0 !== 4'b0010 || st1 !== 4'b0010 || if0.Sout !== 1'b0 || if1.Sout !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: got %b/%b sout %b%b want 0010/0010 sout 00", st0, st1, if0.Sout, if1.Sout);
    end
    lv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (st0 !== 4'b0010 || st1 !== 4'b0010) begin
      errors++;
      $display("FAIL midframe_reset_hold: got %b/%b want 0010/0010", st0, st1);
    end
    lv  = 1'b0;
    clr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (st0 !== 4'b0010 || st1 !== 4'b0010) begin
        errors++;
        $display("FAIL no_done_after_abort: got %b/%b want 0010/0010", st0, st1);
      end
    end
    run_frame(4'b0001, 1'b0, W'($urandom));
    @(negedge clk);
  endtask

  task automatic test_random;
    for (int k = 0; k < 24; k++) begin
      logic [W-1:0] w;
      int gap;
      w   = W'($urandom);
      gap = $urandom_range(0, 3);
      run_frame(w, 1'b0, W'($urandom));
      // gap 0 leaves the next transfer on the Done cycle itself.
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        checks++;
        if (st0 !== 4'b0010 || st1 !== 4'b0010) begin
          errors++;
          $display("FAIL random_gap k=%0d g=%0d: got %b/%b want 0010/0010", k, g, st0, st1);
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fixed_words();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
